// File: rtl/sha_pkg.sv
// Shared constants and FSM state type for the SHA-256 message padder.
// Optional build macro used by sha_padder: SHA_PAD_LE_EN (byte-swapped input).
package sha_pkg;

  localparam int unsigned BLK_WORDS   = 16;
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned LEN_FIELD_W = 64;

  localparam logic [7:0]        PAD_BYTE = 8'h80;
  localparam logic [WORD_W-1:0] PAD_WORD = {PAD_BYTE, 24'h000000};

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_EMIT  = 2'd1,
    ST_EXTRA = 2'd2
  } pad_state_t;

endpackage

// File: rtl/sha_pad_word.sv
// Last-word formatter: keeps the n MSB-aligned data bytes, places the pad
// byte right after them (when there is room) and zeroes everything below.
module sha_pad_word
  import sha_pkg::*;
(
  input  logic [31:0] i_data,
  input  logic [2:0]  i_nbytes,
  output logic [31:0] o_word_c
);

  // Byte mask plus pad insertion; n>=4 passes the word through untouched
  always_comb begin
    o_word_c = i_data;
    case (i_nbytes)
      3'd0:    o_word_c = {PAD_BYTE, 24'h000000};
      3'd1:    o_word_c = {i_data[31:24], PAD_BYTE, 16'h0000};
      3'd2:    o_word_c = {i_data[31:16], PAD_BYTE, 8'h00};
      3'd3:    o_word_c = {i_data[31:8], PAD_BYTE};
      default: o_word_c = i_data;
    endcase
  end

endmodule

// File: rtl/sha_padder.sv
// SHA-256 message padder: packs a 32-bit word stream into 512-bit blocks,
// appending 0x80, zero fill and the 64-bit message bit length.
// Block word i occupies block[32*i+31 : 32*i] (word 0 in the low bits).
// Build macro SHA_PAD_LE_EN: byte-swap in_data so little-endian producers fit.
module sha_padder
  import sha_pkg::*;
#(
  parameter int unsigned LEN_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [2:0]   in_nbytes,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] block,
  output logic         load,
  output logic         blk_last
);

  pad_state_t                   r_state,  w_state_nxt;
  logic [3:0]                   r_widx,   w_widx_nxt;
  logic [LEN_W-1:0]             r_len,    w_len_nxt;
  logic [BLK_WORDS-1:0][31:0]   r_block,  w_block_nxt;
  logic                         r_blk_last, w_blk_last_nxt;
  logic                         r_tail,   w_tail_nxt;
  logic                         r_owe,    w_owe_nxt;

  logic [31:0]            w_data;
  logic [2:0]             w_nb;
  logic                   w_full;
  logic [31:0]            w_pad_word;
  logic [4:0]             w_widx5;
  logic [4:0]             w_pad_pos;
  logic [LEN_W-1:0]       w_len_fin;
  logic [LEN_FIELD_W-1:0] w_fld_fin;
  logic [LEN_FIELD_W-1:0] w_fld_cur;

`ifdef SHA_PAD_LE_EN
  assign w_data = {in_data[7:0], in_data[15:8], in_data[23:16], in_data[31:24]};
`else
  assign w_data = in_data;
`endif

  // Out-of-range byte counts behave as a full word
  assign w_nb      = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
  assign w_full    = (w_nb == 3'd4);
  assign w_widx5   = {1'b0, r_widx};
  // Word that receives the pad byte: this word, or the next one if this is full
  assign w_pad_pos = w_widx5 + {4'd0, w_full};
  assign w_len_fin = r_len + LEN_W'({w_nb, 3'b000});
  assign w_fld_fin = LEN_FIELD_W'(w_len_fin);
  assign w_fld_cur = LEN_FIELD_W'(r_len);

  sha_pad_word u_pad_word (
    .i_data   (w_data),
    .i_nbytes (w_nb),
    .o_word_c (w_pad_word)
  );

  assign in_ready  = (r_state == ST_FILL);
  assign blk_valid = (r_state == ST_EMIT);
  assign load      = blk_valid & blk_ready;
  assign block     = r_block;
  assign blk_last  = r_blk_last;

  // Next-state and datapath update
  always_comb begin
    w_state_nxt    = r_state;
    w_widx_nxt     = r_widx;
    w_len_nxt      = r_len;
    w_block_nxt    = r_block;
    w_blk_last_nxt = r_blk_last;
    w_tail_nxt     = r_tail;
    w_owe_nxt      = r_owe;

    case (r_state)
      ST_FILL: begin
        if (in_valid) begin
          if (in_last) begin
            for (int unsigned i = 0; i < BLK_WORDS; i++) begin
              if (5'(i) == w_widx5)
                w_block_nxt[4'(i)] = w_pad_word;
              else if (5'(i) > w_widx5)
                w_block_nxt[4'(i)] = (w_full && (5'(i) == w_pad_pos)) ? PAD_WORD : 32'h0;
            end
            w_len_nxt  = w_len_fin;
            w_widx_nxt = 4'd0;
            if (w_pad_pos <= 5'd13) begin
              w_block_nxt[14] = w_fld_fin[63:32];
              w_block_nxt[15] = w_fld_fin[31:0];
              w_blk_last_nxt  = 1'b1;
              w_tail_nxt      = 1'b0;
              w_owe_nxt       = 1'b0;
            end else begin
              w_blk_last_nxt  = 1'b0;
              w_tail_nxt      = 1'b1;
              w_owe_nxt       = (w_pad_pos == 5'd16);
            end
            w_state_nxt = ST_EMIT;
          end else begin
            w_block_nxt[r_widx] = w_data;
            w_len_nxt           = r_len + LEN_W'(32);
            w_widx_nxt          = r_widx + 4'd1;
            if (r_widx == 4'd15) begin
              w_blk_last_nxt = 1'b0;
              w_tail_nxt     = 1'b0;
              w_state_nxt    = ST_EMIT;
            end
          end
        end
      end

      ST_EMIT: begin
        if (blk_ready) begin
          if (r_tail) begin
            w_state_nxt = ST_EXTRA;
          end else begin
            w_state_nxt    = ST_FILL;
            w_widx_nxt     = 4'd0;
            w_block_nxt    = '0;
            w_blk_last_nxt = 1'b0;
            if (r_blk_last)
              w_len_nxt = '0;
          end
        end
      end

      ST_EXTRA: begin
        w_block_nxt     = '0;
        w_block_nxt[0]  = r_owe ? PAD_WORD : 32'h0;
        w_block_nxt[14] = w_fld_cur[63:32];
        w_block_nxt[15] = w_fld_cur[31:0];
        w_blk_last_nxt  = 1'b1;
        w_tail_nxt      = 1'b0;
        w_owe_nxt       = 1'b0;
        w_state_nxt     = ST_EMIT;
      end

      default: w_state_nxt = ST_FILL;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_FILL;
      r_widx     <= 4'd0;
      r_len      <= '0;
      r_block    <= '0;
      r_blk_last <= 1'b0;
      r_tail     <= 1'b0;
      r_owe      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_widx     <= w_widx_nxt;
      r_len      <= w_len_nxt;
      r_block    <= w_block_nxt;
      r_blk_last <= w_blk_last_nxt;
      r_tail     <= w_tail_nxt;
      r_owe      <= w_owe_nxt;
    end
  end

endmodule

// File: tb/tb_sha_padder.sv
// Scoreboard bench for sha_padder: a byte-level FIPS 180-4 padding model
// queues expected blocks, a monitor compares every loaded block.
module tb_sha_padder;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [2:0]   in_nbytes;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] block;
  logic         load;
  logic         blk_last;

  typedef struct packed {
    logic [511:0] blk;
    logic         last;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] msg_q[$];
  int         total = 0;
  int         bad   = 0;
  int         n_loads = 0;
  int         blk_idx = 0;

  sha_padder #(.LEN_W(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_nbytes (in_nbytes),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .block     (block),
    .load      (load),
    .blk_last  (blk_last)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference padding built from the raw message bytes
  function automatic void push_model();
    logic [7:0]  p[$];
    logic [63:0] bitlen;
    exp_t        e;
    int          nblk;
    p = msg_q;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    bitlen = 64'(msg_q.size()) * 64'd8;
    for (int k = 7; k >= 0; k--) p.push_back(bitlen[8*k +: 8]);
    nblk = p.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      e.blk = '0;
      for (int i = 0; i < 16; i++)
        e.blk[32*i +: 32] = {p[64*b+4*i], p[64*b+4*i+1], p[64*b+4*i+2], p[64*b+4*i+3]};
      e.last = (b == nblk - 1);
      exp_q.push_back(e);
    end
  endfunction

`ifdef SHA_PAD_LE_EN
  function automatic logic [31:0] bswap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction
`endif

  task automatic drive_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
    int t;
`ifdef SHA_PAD_LE_EN
    in_data = bswap(d);
`else
    in_data = d;
`endif
    in_valid  = 1'b1;
    in_last   = last;
    in_nbytes = nb;
    t = 0;
    while (!in_ready && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 500) check_eq("in_ready_wait", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic fill_rand(input int n);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Send msg_q; unused low bytes of the last word carry random garbage
  task automatic send_msg(input bit trail_empty, input bit bad_nb);
    int          nb;
    int          nw;
    int          rem;
    logic [31:0] d;
    logic [2:0]  lnb;
    bit          lst;
    push_model();
    nb = msg_q.size();
    nw = (nb == 0) ? 1 : (nb + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      d = $urandom;
      for (int b = 0; b < 4; b++)
        if (4*w + b < nb) d[31-8*b -: 8] = msg_q[4*w+b];
      rem = nb - 4*w;
      lnb = (rem >= 4) ? 3'd4 : 3'(rem);
      if (bad_nb && lnb == 3'd4) lnb = 3'd7;
      lst = (w == nw - 1) && !trail_empty;
      drive_word(d, lst, lnb);
    end
    if (trail_empty) drive_word($urandom, 1'b1, 3'd0);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    check_eq("drain", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Scoreboard: every load pulse consumes one expected block
  always @(negedge clk) begin
    exp_t e;
    if (!rst && load) begin
      n_loads++;
      check_eq("load_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < 16; i++)
          check_eq($sformatf("blk%0d_w%0d", blk_idx, i), 64'(block[32*i +: 32]), 64'(e.blk[32*i +: 32]));
        check_eq($sformatf("blk%0d_last", blk_idx), 64'(blk_last), 64'(e.last));
        blk_idx++;
      end
    end
  end

  initial begin
    logic [511:0] held;
    int           l0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    in_nbytes = '0;
    blk_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_blk_valid", 64'(blk_valid), 64'd0);
    check_eq("rst_load", 64'(load), 64'd0);
    check_eq("rst_blk_last", 64'(blk_last), 64'd0);
    check_eq("rst_block_any", 64'(|block), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);

    // "abc" held under backpressure
    blk_ready = 1'b0;
    msg_q = '{8'h61, 8'h62, 8'h63};
    send_msg(1'b0, 1'b0);
    check_eq("abc_latency_valid", 64'(blk_valid), 64'd1);
    check_eq("abc_w0", 64'(block[31:0]), 64'h61626380);
    check_eq("abc_w15", 64'(block[511:480]), 64'h18);
    check_eq("abc_mid_zero", 64'(|block[479:32]), 64'd0);
    check_eq("abc_last", 64'(blk_last), 64'd1);
    held = block;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check_eq("bp_stable", 64'(block != held), 64'd0);
      check_eq("bp_in_ready", 64'(in_ready), 64'd0);
      check_eq("bp_load", 64'(load), 64'd0);
      check_eq("bp_valid", 64'(blk_valid), 64'd1);
    end
    l0 = n_loads;
    blk_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("bp_one_load", 64'(n_loads - l0), 64'd1);
    check_eq("bp_valid_drop", 64'(blk_valid), 64'd0);
    wait_drain();

    // Length and boundary cases
    msg_q.delete(); send_msg(1'b0, 1'b0); wait_drain();  // empty
    fill_rand(56);  send_msg(1'b0, 1'b0); wait_drain();
    fill_rand(64);  send_msg(1'b0, 1'b0); wait_drain();
    fill_rand(64);  send_msg(1'b1, 1'b0); wait_drain();  // trailing empty word
    fill_rand(55);  send_msg(1'b0, 1'b0); wait_drain();
    fill_rand(52);  send_msg(1'b0, 1'b0); wait_drain();
    fill_rand(60);  send_msg(1'b0, 1'b0); wait_drain();
    fill_rand(63);  send_msg(1'b0, 1'b0); wait_drain();
    fill_rand(8);   send_msg(1'b0, 1'b1); wait_drain();  // nbytes=7 acts as 4
    fill_rand(130); send_msg(1'b0, 1'b0); wait_drain();
    fill_rand(4);   send_msg(1'b1, 1'b0); wait_drain();

    // Reset after 7 words discards the partial block
    for (int w = 0; w < 7; w++) drive_word($urandom, 1'b0, 3'd4);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", 64'(blk_valid), 64'd0);
    check_eq("mid_rst_load", 64'(load), 64'd0);
    check_eq("mid_rst_block", 64'(|block), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("mid_rst_in_ready", 64'(in_ready), 64'd1);
    msg_q = '{8'h61, 8'h62, 8'h63};
    send_msg(1'b0, 1'b0);
    check_eq("post_rst_w15", 64'(block[511:480]), 64'h18);
    wait_drain();

    // Reset while a full block waits in EMIT
    blk_ready = 1'b0;
    for (int w = 0; w < 16; w++) drive_word($urandom, 1'b0, 3'd4);
    check_eq("emit_hold_valid", 64'(blk_valid), 64'd1);
    rst = 1'b1;
    #1;
    check_eq("emit_rst_valid", 64'(blk_valid), 64'd0);
    check_eq("emit_rst_block", 64'(|block), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    blk_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("emit_rst_idle", 64'(blk_valid), 64'd0);
    msg_q = '{8'h61, 8'h62, 8'h63};
    send_msg(1'b0, 1'b0);
    wait_drain();

    check_eq("final_q_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
